// File: rtl/cdc_pkg.sv
// Shared types for the req/ack clock-domain-crossing handshake blocks.
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    ACK_LOW = 2'd2
  } state_t;

  localparam int MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/cdc_ack_sync.sv
// Multi-flop bit synchronizer for the asynchronous acknowledge returning from the remote domain.
module cdc_ack_sync
  import cdc_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  // Fewer than two flops gives no metastability protection, so the chain never goes shorter.
  localparam int STAGES = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], async_in};
    end
  end

  assign sync_out = chain[STAGES-1];

endmodule

// File: rtl/cdc_hs_tx.sv
// Transmit half of a 4-phase req/ack CDC handshake; data_o is held from req rise to handshake end.
// Optional REQ-phase timeout is compiled in with `define CDC_HS_TX_TIMEOUT_EN.
module cdc_hs_tx
  import cdc_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              req_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              ack_i,
  output logic              busy,
  output logic              timeout_o
);

  state_t            state;
  state_t            state_nxt;
  logic              req_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic              ack_sync;

  cdc_ack_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (ack_i),
    .sync_out (ack_sync)
  );

`ifdef CDC_HS_TX_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             timeout_nxt;
  logic             cnt_expired;

  assign cnt_expired = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      req_o  <= 1'b0;
      data_o <= '0;
`ifdef CDC_HS_TX_TIMEOUT_EN
      cnt       <= '0;
      timeout_o <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      req_o  <= req_nxt;
      data_o <= data_nxt;
`ifdef CDC_HS_TX_TIMEOUT_EN
      cnt       <= cnt_nxt;
      timeout_o <= timeout_nxt;
`endif
    end
  end

  // Only the synchronized ack steers the FSM; an ack seen while idle is simply not looked at.
  always_comb begin
    state_nxt = state;
    req_nxt   = req_o;
    data_nxt  = data_o;
`ifdef CDC_HS_TX_TIMEOUT_EN
    cnt_nxt     = cnt;
    timeout_nxt = 1'b0;
`endif
    case (state)
      IDLE: begin
        req_nxt = 1'b0;
        if (s_valid) begin
          data_nxt  = s_data;
          req_nxt   = 1'b1;
          state_nxt = REQ;
`ifdef CDC_HS_TX_TIMEOUT_EN
          cnt_nxt = '0;
`endif
        end
      end
      REQ: begin
        req_nxt = 1'b1;
`ifdef CDC_HS_TX_TIMEOUT_EN
        cnt_nxt = cnt + 1'b1;
`endif
        if (ack_sync) begin
          req_nxt   = 1'b0;
          state_nxt = ACK_LOW;
        end
`ifdef CDC_HS_TX_TIMEOUT_EN
        else if (cnt_expired) begin
          req_nxt     = 1'b0;
          timeout_nxt = 1'b1;
          state_nxt   = ACK_LOW;
        end
`endif
      end
      ACK_LOW: begin
        req_nxt = 1'b0;
        if (!ack_sync) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        req_nxt   = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    s_ready = (state == IDLE);
    busy    = (state != IDLE);
  end

`ifndef CDC_HS_TX_TIMEOUT_EN
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_hs_tx.sv
// Self-checking bench for cdc_hs_tx with a delayed/echoing remote-side model.
module tb_cdc_hs_tx;

  localparam int DATA_W  = 8;
  localparam int SYNC    = 2;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] s_data = '0;
  logic              req_o;
  logic [DATA_W-1:0] data_o;
  logic              ack_i;
  logic              busy;
  logic              timeout_o;

  int errors = 0;
  int checks = 0;

  // Remote-side model: ack follows req after a chosen delay, or echoes it instantly.
  int          delay = 3;
  bit          echo = 1'b0;
  bit          ack_force_en = 1'b0;
  bit          ack_force_val = 1'b0;
  logic [7:0]  pipe = '0;
  logic        req_prev = 1'b0;
  logic [DATA_W-1:0] rx_q[$];
  logic [DATA_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  assign ack_i = ack_force_en ? ack_force_val : (echo ? req_o : pipe[delay-1]);

  always @(posedge clk) begin
    pipe     <= {pipe[6:0], req_o};
    req_prev <= req_o;
    if (req_o && !req_prev) rx_q.push_back(data_o);
  end

  cdc_hs_tx #(
    .DATA_W         (DATA_W),
    .SYNC_STAGES    (SYNC),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .req_o     (req_o),
    .data_o    (data_o),
    .ack_i     (ack_i),
    .busy      (busy),
    .timeout_o (timeout_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Presents a word and returns just after the edge that accepted it.
  task automatic applyStimulus(input logic [DATA_W-1:0] w, output bit accepted);
    accepted = 1'b0;
    s_valid  = 1'b1;
    s_data   = w;
    for (int i = 0; i < 300 && !accepted; i++) begin
      if (s_ready) accepted = 1'b1;
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic waitIdle(input int settle);
    for (int i = 0; i < 300 && !s_ready; i++) tick();
    for (int i = 0; i < settle; i++) tick();
  endtask

  // One full handshake; expected event times come from the delay rules of the handshake.
  task automatic runTransfer(input logic [DATA_W-1:0] w, input int d, input bit ech, input string tag);
    bit acc;
    int t;
    int t_ack_rise = -1;
    int t_req_fall = -1;
    int t_ack_fall = -1;
    bit prev_ack;
    bit prev_req;
    bit unstable = 1'b0;
    bit saw_timeout = 1'b0;
    delay = (d < 1) ? 1 : d;
    echo  = ech;
    applyStimulus(w, acc);
    checkOutput({tag, "_accepted"}, 32'(acc), 32'd1);
    if (!acc) return;
    exp_q.push_back(w);
    t = 1;
    checkOutput({tag, "_req_rise"}, 32'(req_o), 32'd1);
    checkOutput({tag, "_data"}, 32'(data_o), 32'(w));
    checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    prev_ack = 1'b0;
    prev_req = 1'b1;
    if (ack_i) begin t_ack_rise = 1; prev_ack = 1'b1; end
    while (!s_ready && t < 300) begin
      tick();
      t++;
      if (data_o !== w || busy !== !s_ready) unstable = 1'b1;
      if (timeout_o) saw_timeout = 1'b1;
      if (ack_i && !prev_ack) t_ack_rise = t;
      if (!ack_i && prev_ack) t_ack_fall = t;
      if (!req_o && prev_req) t_req_fall = t;
      prev_ack = ack_i;
      prev_req = req_o;
    end
    checkOutput({tag, "_data_stable"}, 32'(unstable), 32'd0);
    checkOutput({tag, "_no_timeout"}, 32'(saw_timeout), 32'd0);
    checkOutput({tag, "_ack_to_req_fall"}, 32'(t_req_fall - t_ack_rise), 32'(SYNC + 1));
    checkOutput({tag, "_ackfall_to_ready"}, 32'(t - t_ack_fall), 32'(SYNC + 1));
    checkOutput({tag, "_total"}, 32'(t), 32'(1 + 2 * (ech ? 0 : delay) + 2 * (SYNC + 1)));
  endtask

  task automatic compareRx(input string tag);
    checkOutput({tag, "_rx_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      checkOutput({tag, "_rx_word"}, 32'(rx_q[i]), 32'(exp_q[i]));
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    bit acc;
    int k;
    int accepts;
    logic [DATA_W-1:0] words [3];

    // Reset and idle state
    rst = 1'b1;
    tick();
    tick();
    checkOutput("rst_s_ready", 32'(s_ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();
    checkOutput("idle_s_ready", 32'(s_ready), 32'd1);
    checkOutput("idle_req", 32'(req_o), 32'd0);
    checkOutput("idle_data", 32'(data_o), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_timeout", 32'(timeout_o), 32'd0);
    rx_q.delete();

    // Nominal transfer with 3-cycle remote delay
    runTransfer(8'hA5, 3, 1'b0, "nominal");
    compareRx("nominal");

    // Instant echo gives the minimum handshake length
    waitIdle(2);
    runTransfer(8'h5A, 0, 1'b1, "echo");
    compareRx("echo");

    // Back-to-back words with s_valid held high
    waitIdle(2);
    delay = 2;
    echo = 1'b0;
    words[0] = 8'h01;
    words[1] = 8'h02;
    words[2] = 8'h03;
    k = 0;
    accepts = 0;
    s_valid = 1'b1;
    for (int c = 0; c < 200 && k < 3; c++) begin
      s_data = words[k];
      if (s_ready) begin
        tick();
        exp_q.push_back(words[k]);
        k++;
        accepts++;
        if (busy !== 1'b1) checkOutput("b2b_busy_after_accept", 32'(busy), 32'd1);
      end else begin
        tick();
      end
    end
    s_valid = 1'b0;
    waitIdle(6);
    checkOutput("b2b_accepts", 32'(accepts), 32'd3);
    compareRx("b2b");

    // Spurious ack while idle is ignored
    ack_force_en = 1'b1;
    ack_force_val = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checkOutput("spurious_ready", 32'(s_ready), 32'd1);
    checkOutput("spurious_req", 32'(req_o), 32'd0);
    ack_force_val = 1'b0;
    for (int i = 0; i < SYNC + 1; i++) tick();
    ack_force_en = 1'b0;

    // Reset during REQ aborts the handshake
    delay = 4;
    applyStimulus(8'h77, acc);
    checkOutput("abort_accepted", 32'(acc), 32'd1);
    exp_q.push_back(8'h77);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort_req", 32'(req_o), 32'd0);
    checkOutput("abort_ready", 32'(s_ready), 32'd1);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 10; i++) tick();
    runTransfer(8'h3C, 3, 1'b0, "post_abort");
    compareRx("abort");

    // Randomized transfers against the latency rules
    for (int n = 0; n < 6; n++) begin
      waitIdle($urandom_range(1, 4));
      runTransfer(DATA_W'($urandom), int'($urandom_range(1, 4)), bit'($urandom_range(0, 1)), "rand");
    end
    waitIdle(6);
    compareRx("rand");

`ifdef CDC_HS_TX_TIMEOUT_EN
    // Remote never acknowledges: REQ times out
    ack_force_en = 1'b1;
    ack_force_val = 1'b0;
    applyStimulus(8'hC3, acc);
    checkOutput("tmo_accepted", 32'(acc), 32'd1);
    k = 0;
    while (!timeout_o && k < 100) begin
      tick();
      k++;
    end
    checkOutput("tmo_cycles", 32'(k), 32'(TIMEOUT));
    checkOutput("tmo_req_drop", 32'(req_o), 32'd0);
    tick();
    checkOutput("tmo_pulse_end", 32'(timeout_o), 32'd0);
    checkOutput("tmo_idle", 32'(s_ready), 32'd1);
    ack_force_en = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cdc_hs_tx.md
Name: cdc_hs_tx

Overview:
- Source-side (transmitter) half of a 4-phase req/ack clock-domain-crossing handshake.
- Accepts a data word through a valid/ready interface in the local clock domain and drives req_o and data_o towards a remote domain.
- The remote side samples req_o through a bit synchronizer. This block synchronizes the returning asynchronous ack_i internally.
- Holds data_o stable from req_o rise until the full handshake completes.

Parameters:
DATA_W, 8, width of the transferred data word
SYNC_STAGES, 2, flop stages in the ack_i synchronizer (legal range 2..4)
TIMEOUT_CYCLES, 1024, REQ-phase timeout in clk cycles; used only when the optional feature is compiled in

Ports:
clk  input  1  clock; all logic on the rising edge
rst  input  1  synchronous reset, active-high
s_valid  input  1  upstream word valid
s_ready  output  1  block can accept a word this cycle
s_data  input  DATA_W  upstream word
req_o  output  1  handshake request to the remote domain (registered)
data_o  output  DATA_W  held data to the remote domain (registered)
ack_i  input  1  handshake acknowledge from the remote domain (asynchronous)
busy  output  1  handshake in progress (state != IDLE)
timeout_o  output  1  one-cycle timeout pulse (tied 0 when the feature is absent)

Behaviour:
- Reset is synchronous, sampled at a clk edge with rst=1.
  - Reset values: state=IDLE, req_o=0, data_o=0, sync flops=0, timeout_o=0, counter=0.
  - Combinational outputs during reset: s_ready=1, busy=0.
- ack_sync is the last flop of the SYNC_STAGES-deep chain on ack_i. The FSM uses only ack_sync, never ack_i.
- s_ready = (state==IDLE). It is combinational from state only, with no path from s_valid.
- IDLE:
  - On an edge with s_valid=1: data_o<=s_data, req_o<=1, go to REQ.
  - req_o is visible 1 cycle after the accepting edge.
- REQ: req_o=1. When ack_sync=1: req_o<=0, go to ACK_LOW.
- ACK_LOW: req_o=0. When ack_sync=0: go to IDLE, and s_ready=1 from the next cycle.
- data_o changes only on an accepting edge and is stable through REQ and ACK_LOW.
- Minimum handshake length with an instant remote echo (ack_i=req_o combinationally): 2*(SYNC_STAGES+1)+1 cycles from accept to s_ready=1. With SYNC_STAGES=2 this is 7 cycles.
- An ack_sync=1 seen in IDLE (spurious ack) is ignored. It does not block acceptance.
- s_valid is ignored while busy. Upstream must hold the word until s_ready.
- Reset mid-handshake: req_o drops at the reset edge and the FSM returns to IDLE. The remote side must tolerate an aborted request.
- The FSM has exactly three states. Any unused encoding recovers to IDLE.

Optional Feature:
- Macro: CDC_HS_TX_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to REQ and increments each cycle in REQ.
  - When it reaches TIMEOUT_CYCLES-1 with ack_sync still 0, then at the next edge: req_o<=0, go to ACK_LOW, and timeout_o=1 for exactly 1 cycle.
  - ACK_LOW waits with no timeout.
  - Counter width is clog2(TIMEOUT_CYCLES).
- Undefined: no counter is built, timeout_o is tied to 0, and REQ waits indefinitely.

Decomposition:
- Shared package cdc_pkg holds:
  - the state typedef (IDLE=2'd0, REQ=2'd1, ACK_LOW=2'd2);
  - the localparam for the minimum sync stages (2).
- One sub-module, cdc_ack_sync: a parameterized SYNC_STAGES flop chain with synchronous active-high reset. It is instantiated once for ack_i.

Test Plan:
- Reset, then idle: check s_ready=1, req_o=0, data_o=0, busy=0 with ack_i=0.
- Nominal transfer, s_data=8'hA5, remote modelled as ack_i following req_o after 3 cycles:
  - req_o rises 1 cycle after accept;
  - data_o=8'hA5 and stable until IDLE;
  - req_o falls SYNC_STAGES+1 cycles after ack_i rises;
  - s_ready returns SYNC_STAGES+1 cycles after ack_i falls.
- Back-to-back words 8'h01, 8'h02, 8'h03 with s_valid held high: each is accepted only in IDLE, no word is lost or duplicated, and the remote model receives 01,02,03 in order.
- Instant echo (ack_i=req_o): accept to next s_ready is exactly 7 cycles with SYNC_STAGES=2.
- rst asserted during REQ: req_o=0 and state IDLE at the next edge. A subsequent word 8'h3C transfers normally.
- With CDC_HS_TX_TIMEOUT_EN defined and TIMEOUT_CYCLES=16, ack_i held 0:
  - timeout_o pulses once, 16 cycles after REQ entry;
  - req_o drops at the same edge;
  - block returns to IDLE.
